// File: rtl/cpu_prog_loader_if.sv
// Program-stream and memory-write bus between the host/debug port, the loader and CPU memory.
// The master drives program words in and observes the resulting memory writes.
interface cpu_prog_loader_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);
  logic [DWIDTH-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/cpu_prog_loader.sv
// Loads a program image into CPU memory with the CPU held in reset, releases it,
// then captures the halt PC and a pass/fail/timeout verdict.
module cpu_prog_loader #(
  parameter int AWIDTH     = 5,
  parameter int DWIDTH     = 8,
  parameter int DEPTH      = 32,
  parameter int RST_CYCLES = 2,
  parameter int MAX_CYCLES = 1024
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [AWIDTH-1:0] expected_pc,
  cpu_prog_loader_if.slave  bus,
  output logic              cpu_rst,
  input  logic              halt,
  input  logic [AWIDTH-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [AWIDTH-1:0] halt_pc
);

  localparam int CW  = (DEPTH > 1)      ? $clog2(DEPTH)      : 1;
  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int RW  = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

  localparam logic [CW-1:0]  CNT_LAST = CW'(DEPTH - 1);
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [RW-1:0]  RUN_LAST = RW'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CPURST,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RCW-1:0]    rst_cnt_q, rst_cnt_d;
  logic [RW-1:0]     run_cnt_q, run_cnt_d;
  logic [AWIDTH-1:0] exp_q, exp_d;
  logic              halt_hist_q, halt_hist_d;
  logic              mem_we_q, mem_we_d;
  logic [AWIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DWIDTH-1:0] mem_data_q, mem_data_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [AWIDTH-1:0] halt_pc_q, halt_pc_d;

  logic in_ready;
  logic xfer;
  logic halt_evt;

  // in_ready depends on state alone so the upstream valid never loops back combinationally
  assign in_ready = (state_q == S_LOAD);
  assign xfer     = in_ready & bus.in_valid;
  assign halt_evt = (state_q == S_RUN) & halt & ~halt_hist_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rst_cnt_d   = rst_cnt_q;
    run_cnt_d   = run_cnt_q;
    exp_d       = exp_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    halt_pc_d   = halt_pc_q;
    // History pinned high outside RUN so a halt already asserted at release is not an event
    halt_hist_d = (state_q == S_RUN) ? halt : 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_LOAD;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          exp_d     = expected_pc;
          cnt_d     = '0;
          rst_cnt_d = '0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          mem_we_d   = 1'b1;
          mem_addr_d = AWIDTH'(cnt_q);
          mem_data_d = bus.in_data;
          if (cnt_q == CNT_LAST) begin
            state_d   = S_CPURST;
            rst_cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      S_CPURST: begin
        run_cnt_d = '0;
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + RCW'(1);
        end
      end
      S_RUN: begin
        // A halt on the final run cycle takes priority over the timeout
        if (halt_evt) begin
          halt_pc_d = pc;
          pass_d    = (pc == exp_q);
          timeout_d = 1'b0;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else if (run_cnt_q == RUN_LAST) begin
          halt_pc_d = pc;
          pass_d    = 1'b0;
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          run_cnt_d = run_cnt_q + RW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rst_cnt_q   <= '0;
      run_cnt_q   <= '0;
      exp_q       <= '0;
      halt_hist_q <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      halt_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_cnt_q   <= rst_cnt_d;
      run_cnt_q   <= run_cnt_d;
      exp_q       <= exp_d;
      halt_hist_q <= halt_hist_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      halt_pc_q   <= halt_pc_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;

  // The CPU runs only in RUN; reset state decodes to IDLE so cpu_rst asserts asynchronously
  assign cpu_rst = (state_q != S_RUN);
  assign busy    = (state_q == S_LOAD) || (state_q == S_CPURST) || (state_q == S_RUN);
  assign done    = done_q;
  assign pass    = pass_q;
  assign timeout = timeout_q;
  assign halt_pc = halt_pc_q;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Directed bench for cpu_prog_loader: load with gaps, release timing, halt pass/fail,
// timeout, halt/timeout tie, rerun, ignored starts and asynchronous reset mid-load.
module tb_cpu_prog_loader;
  localparam int AW = 5;
  localparam int DW = 8;
  localparam int NW = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          halt = 1'b0;
  logic [AW-1:0] expected_pc = '0;
  logic [AW-1:0] pc = '0;
  logic          cpu_rst, busy, done, pass, timeout;
  logic [AW-1:0] halt_pc;

  cpu_prog_loader_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();

  cpu_prog_loader #(
    .AWIDTH(AW), .DWIDTH(DW), .DEPTH(NW), .RST_CYCLES(2), .MAX_CYCLES(16)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .expected_pc(expected_pc), .bus(bus.slave),
    .cpu_rst(cpu_rst), .halt(halt), .pc(pc), .busy(busy), .done(done),
    .pass(pass), .timeout(timeout), .halt_pc(halt_pc)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [AW-1:0] wa [64];
  logic [DW-1:0] wd [64];
  int            wc [64];
  int            xc [64];
  int            wn = 0;

  always @(negedge CLK) begin
    if (bus.mem_we) begin
      if (wn < 64) begin
        wa[wn] = bus.mem_addr;
        wd[wn] = bus.mem_data;
        wc[wn] = cyc;
      end
      wn = wn + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Starts a load at a negedge, streams NW words (data k ^ xv), pulses a stray start
  // mid-load, and returns at the negedge of the first RUN cycle.
  task automatic load(input logic [DW-1:0] xv, input bit gaps,
                      input logic [AW-1:0] exp_pc, input logic [AW-1:0] bogus);
    int k;
    int c;
    k = 0;
    c = 0;
    wn = 0;
    start = 1'b1;
    expected_pc = exp_pc;
    @(negedge CLK);
    start = 1'b0;
    chk("load_ready", 32'(bus.in_ready), 1);
    chk("load_done_clr", 32'(done), 0);
    chk("load_pass_clr", 32'(pass), 0);
    chk("load_to_clr", 32'(timeout), 0);
    while (k < NW && c < 200) begin
      bus.in_valid = !(gaps && (c % 3 == 2));
      bus.in_data  = DW'(k) ^ xv;
      if (k == 10) begin
        start = 1'b1;
        expected_pc = bogus;
      end else begin
        start = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        xc[k] = cyc;
        k++;
      end
      @(negedge CLK);
      c++;
    end
    start = 1'b0;
    bus.in_valid = 1'b0;
    if (c >= 200) chk("load_bound", 0, 1);
    chk("rst1_ready", 32'(bus.in_ready), 0);
    chk("rst1_cpu_rst", 32'(cpu_rst), 1);
    chk("rst1_busy", 32'(busy), 1);
    @(negedge CLK);
    chk("rst2_cpu_rst", 32'(cpu_rst), 1);
    chk("rst2_busy", 32'(busy), 1);
    @(negedge CLK);
    chk("run_cpu_rst", 32'(cpu_rst), 0);
    chk("run_busy", 32'(busy), 1);
    chk("wr_count", 32'(wn), NW);
    for (int i = 0; i < NW; i++) begin
      chk("wr_addr", 32'(wa[i]), 32'(i));
      chk("wr_data", 32'(wd[i]), 32'(DW'(i) ^ xv));
      chk("wr_lat", 32'(wc[i]), 32'(xc[i] + 1));
    end
  endtask

  initial begin
    int w0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge CLK);
    chk("rst_cpu_rst", 32'(cpu_rst), 1);
    chk("rst_ready", 32'(bus.in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_halt_pc", 32'(halt_pc), 0);
    RST = 1'b0;

    // Idle with valid data on the bus and no start: nothing is accepted or written
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    repeat (5) @(negedge CLK);
    chk("idle_no_write", 32'(wn), 0);
    chk("idle_ready", 32'(bus.in_ready), 0);
    chk("idle_cpu_rst", 32'(cpu_rst), 1);
    bus.in_valid = 1'b0;

    // Load 1 with gaps; halt at expected PC
    load(8'h00, 1'b1, 5'h17, 5'h03);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    chk("run_start_ign", 32'(busy), 1);
    pc = 5'h17;
    halt = 1'b1;
    @(negedge CLK);
    chk("h1_done", 32'(done), 1);
    chk("h1_pass", 32'(pass), 1);
    chk("h1_timeout", 32'(timeout), 0);
    chk("h1_halt_pc", 32'(halt_pc), 32'h17);
    chk("h1_cpu_rst", 32'(cpu_rst), 1);
    chk("h1_busy", 32'(busy), 0);

    // Load 2 with halt held high from RUN entry, then a real halt at the wrong PC
    load(8'hA5, 1'b0, 5'h10, 5'h0C);
    repeat (3) @(negedge CLK);
    chk("held_halt_ign", 32'(done), 0);
    chk("held_halt_busy", 32'(busy), 1);
    halt = 1'b0;
    @(negedge CLK);
    pc = 5'h0C;
    halt = 1'b1;
    @(negedge CLK);
    chk("h2_done", 32'(done), 1);
    chk("h2_pass", 32'(pass), 0);
    chk("h2_halt_pc", 32'(halt_pc), 32'h0C);
    chk("h2_cpu_rst", 32'(cpu_rst), 1);
    halt = 1'b0;

    // Timeout: PC equals expected but halt never rises
    load(8'h3C, 1'b0, 5'h05, 5'h1E);
    pc = 5'h05;
    repeat (15) @(negedge CLK);
    chk("to_not_yet", 32'(done), 0);
    @(negedge CLK);
    chk("to_done", 32'(done), 1);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_pass", 32'(pass), 0);
    chk("to_halt_pc", 32'(halt_pc), 32'h05);

    // Tie: halt rises on the last run cycle
    load(8'h5A, 1'b0, 5'h09, 5'h00);
    pc = 5'h09;
    repeat (15) @(negedge CLK);
    halt = 1'b1;
    chk("tie_not_yet", 32'(done), 0);
    @(negedge CLK);
    chk("tie_done", 32'(done), 1);
    chk("tie_timeout", 32'(timeout), 0);
    chk("tie_pass", 32'(pass), 1);
    chk("tie_halt_pc", 32'(halt_pc), 32'h09);
    halt = 1'b0;

    // Asynchronous reset mid-load
    start = 1'b1;
    expected_pc = 5'h01;
    @(negedge CLK);
    start = 1'b0;
    bus.in_valid = 1'b1;
    repeat (5) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_cpu_rst", 32'(cpu_rst), 1);
    chk("arst_ready", 32'(bus.in_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_halt_pc", 32'(halt_pc), 0);
    chk("arst_we", 32'(bus.mem_we), 0);
    @(negedge CLK);
    RST = 1'b0;
    w0 = wn;
    repeat (6) @(negedge CLK);
    chk("post_rst_no_write", 32'(wn), 32'(w0));
    chk("post_rst_ready", 32'(bus.in_ready), 0);
    chk("post_rst_cpu_rst", 32'(cpu_rst), 1);
    chk("post_rst_halt_pc", 32'(halt_pc), 0);
    bus.in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/cpu_prog_loader.md
Name: cpu_prog_loader

Overview:
- Hardware counterpart of the CPU bench flow.
- Streams a program image into the CPU instruction/data memory through a valid/ready byte interface, holding the CPU in reset while it loads.
- Then releases the CPU, waits for HALT, and captures the halt PC and a pass/fail verdict against an expected halt address.
- Sits between a host/debug port and the cpu block's memory write port and reset.

Parameters:
- AWIDTH, 5, memory address and PC width.
- DWIDTH, 8, memory word width.
- DEPTH, 32, number of words loaded per program; must equal 2**AWIDTH or less.
- RST_CYCLES, 2, cycles cpu_rst is held after load completes; must be at least 1.
- MAX_CYCLES, 1024, run-cycle limit before timeout.

Ports:
- CLK  in  1  system clock, all logic on posedge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE or DONE.
- expected_pc  in  AWIDTH  expected halt address, sampled on an accepted start.
- in_data  in  DWIDTH  program word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a word this cycle.
- mem_we  out  1  memory write strobe.
- mem_addr  out  AWIDTH  memory write address.
- mem_data  out  DWIDTH  memory write data.
- cpu_rst  out  1  reset to the cpu block.
- halt  in  1  CPU HALT.
- pc  in  AWIDTH  CPU program counter.
- busy  out  1  state is LOAD, CPURST or RUN.
- done  out  1  result valid.
- pass  out  1  halt_pc equals expected_pc, and no timeout.
- timeout  out  1  run-cycle limit hit before halt.
- halt_pc  out  AWIDTH  captured PC.

Behaviour:
- States are IDLE, LOAD, CPURST, RUN and DONE.
- On RST (async):
  - state = IDLE.
  - cpu_rst = 1; in_ready, mem_we, busy, done, pass and timeout = 0.
  - mem_addr, mem_data and halt_pc = 0.
  - Word count, run counter and expected register are cleared.
- IDLE/DONE:
  - cpu_rst = 1.
  - On start: clear done/pass/timeout, latch expected_pc, word count = 0, go to LOAD next cycle.
  - Result outputs hold until then.
  - start in any other state is ignored.
- LOAD:
  - in_ready = 1, decoded from state only (no combinational path from in_valid).
  - A transfer occurs on in_valid & in_ready. The following cycle mem_we = 1, mem_addr = count, mem_data = in_data. Write latency is 1 cycle.
  - count increments per transfer.
  - Gaps (in_valid low) are allowed and produce no write.
  - The transfer at count = DEPTH-1 moves state to CPURST; in_ready is 0 from the next cycle.
  - Exactly DEPTH writes occur, at addresses 0..DEPTH-1.
- CPURST:
  - cpu_rst = 1 for exactly RST_CYCLES cycles. The last memory write overlaps the first of these cycles.
  - Then RUN, with cpu_rst = 0 from the first RUN cycle.
- RUN:
  - Run counter increments every cycle from 0.
  - Halt detection is a rising edge of registered halt. The halt history register is forced to 1 outside RUN, so a halt already high on RUN entry is not an event.
  - On a halt event:
    - halt_pc <= pc, sampled the same cycle halt is first seen high.
    - pass <= (pc == expected), timeout <= 0, done <= 1.
    - Go to DONE; cpu_rst reasserts in DONE.
  - If the counter reaches MAX_CYCLES-1 with no halt event: timeout <= 1, pass <= 0, halt_pc <= pc, done <= 1, go to DONE.
  - If a halt event and timeout occur in the same cycle, halt wins.
- General rules:
  - in_valid outside LOAD is ignored and produces no write.
  - RST mid-LOAD/RUN aborts to IDLE. Memory contents already written are not cleared. cpu_rst is 1 immediately (async).
  - Counter widths are clog2-sized. There is no wrap: the word count never exceeds DEPTH-1 and the run counter stops at the limit.

Test Plan:
- Reset then idle: RST pulse mid-operation -> cpu_rst = 1, in_ready = 0, done = 0, halt_pc = 0 immediately and held; start absent -> no mem_we ever.
- Full load with gaps: start with expected_pc = 5'h17; 32 words 8'h00..8'h1F with in_valid deasserted every 3rd cycle -> exactly 32 mem_we pulses, mem_addr k carries data k, each 1 cycle after its transfer; in_ready low the cycle after word 31.
- Release timing: after the last transfer with RST_CYCLES = 2 -> cpu_rst high 2 more cycles then low; busy high throughout.
- Halt pass/fail: drive pc = 5'h17 and a halt rise -> done = 1, pass = 1, halt_pc = 17. Repeat with expected 5'h10 and halt at 5'h0C -> pass = 0, halt_pc = 0C, cpu_rst back to 1.
- Timeout and tie: MAX_CYCLES = 16 with halt never rising -> done and timeout on run cycle 15, pass = 0. Halt rising on cycle 15 -> timeout = 0 and halt result captured. Halt held high from RUN entry -> ignored.
- Rerun: start in DONE -> outputs cleared and a second load proceeds; start pulsed during LOAD/RUN -> no effect.
